resp_uart_tx: RTL and testbench

- Transmit end of the response-buffer interface.
- A command block presents a byte buffer, a byte count and a ready level. This block captures them and serializes the bytes over the host UART TX line as 8N1 frames, LSB first.
- Sits between command/response generators and the board UART pin.
- Reports busy and a one-cycle done pulse so the controller can sequence the next response.

---
 rtl/resp_uart_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 118 +++++++++++
 rtl/resp_uart_tx.sv | 123 ++++++++++++
 tb/tb_resp_uart_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/resp_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resp_uart_pkg
// Description : Shared types and constants for the response-buffer UART
//               transmitter. It holds the serializer state encoding and the
//               frame/buffer geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package resp_uart_pkg;

    // Serializer phases of one 8N1 frame
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int FRAME_BITS = 10;   // start + 8 data + stop
    localparam int DATA_BITS  = 8;
    localparam int BUF_BYTES  = 16;   // only the low half of the 256-bit buffer

endpackage : resp_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : Single-byte 8N1 serializer, LSB first. A start request in
//               IDLE, or in the final cycle of STOP, loads byte_i and begins
//               the start bit on the next edge. This allows frames to be
//               chained with no idle gap.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start_i, byte_i   - load request and byte to send
//               tx_o              - registered serial output, idles high
//               frame_done_o      - high in the last cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import resp_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] byte_i,
    output logic                 tx_o,
    output logic                 frame_done_o
);

    localparam int             TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  C_TICK     = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     C_LAST_BIT = 3'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   w_tick;

    assign w_tick = (timer_q == C_TICK);
    assign tx_o   = tx_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        tx_d         = tx_q;
        frame_done_o = 1'b0;

        // Bit timer free-runs 0..CLKS_PER_BIT-1 while a frame is in flight
        if (state_q != ST_IDLE) begin
            timer_d = w_tick ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (start_i) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    shreg_d = byte_i;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (bit_q == C_LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    frame_done_o = 1'b1;
                    if (start_i) begin
                        // Chain straight into the next frame's start bit
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        shreg_d = byte_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/resp_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : resp_uart_tx
// Description : Response-buffer UART transmitter. On a rising edge of in_rdy
//               while idle, it captures up to 16 bytes and a byte count. It
//               then sends the bytes back to back as 8N1 frames and signals
//               completion with a one-cycle done pulse.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               in_data        - byte k on [8k+7:8k]; only bytes 0..15 are used
//               in_bytecount   - bytes to send minus one
//               in_rdy         - request level; its rising edge starts a transfer
//               tx             - UART serial output, idles high
//               busy           - transfer in progress
//               done           - one-cycle pulse after the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module resp_uart_tx
    import resp_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] in_data,
    input  logic [3:0]   in_bytecount,
    input  logic         in_rdy,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int C_BUF_W = BUF_BYTES * DATA_BITS;

    logic [C_BUF_W-1:0]   data_q, data_d;
    logic [3:0]           count_q, count_d;
    logic [3:0]           byte_idx_q, byte_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_q, start_d;
    logic                 rdy_q;

    logic                 w_start_cond;
    logic                 w_frame_done;
    logic                 w_last;
    logic                 w_ser_start;
    logic [3:0]           w_sel_idx;
    logic [DATA_BITS-1:0] w_ser_byte;
    logic                 w_unused_hi;

    // The upper half of the buffer is never transmitted
    assign w_unused_hi = ^in_data[255:C_BUF_W];

    // done_q gating keeps the earliest new start one cycle after the pulse
    assign w_start_cond = !busy_q && !done_q && in_rdy && !rdy_q;
    assign w_last       = (byte_idx_q == count_q);

    // The first byte is launched by start_q. Each later byte is offered while
    // the current stop bit ends, so the serializer chains frames seamlessly.
    assign w_ser_start  = start_q | (busy_q && w_frame_done && !w_last);
    assign w_sel_idx    = start_q ? byte_idx_q : byte_idx_q + 4'd1;
    assign w_ser_byte   = data_q[{w_sel_idx, 3'b000} +: DATA_BITS];

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        data_d     = data_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start_d    = 1'b0;

        if (w_start_cond) begin
            data_d     = in_data[C_BUF_W-1:0];
            count_d    = in_bytecount;
            byte_idx_d = '0;
            busy_d     = 1'b1;
            start_d    = 1'b1;
        end else if (busy_q && w_frame_done) begin
            if (w_last) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            // Reset high so a level already present at release is not an edge
            rdy_q      <= 1'b1;
        end else begin
            data_q     <= data_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_q    <= start_d;
            rdy_q      <= in_rdy;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk          (clk),
        .rst          (rst),
        .start_i      (w_ser_start),
        .byte_i       (w_ser_byte),
        .tx_o         (tx),
        .frame_done_o (w_frame_done)
    );

endmodule : resp_uart_tx
`default_nettype wire

// File: tb/tb_resp_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_uart_tx
// Description : Directed self-checking bench for resp_uart_tx with
//               CLKS_PER_BIT=4. Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 10 * CPB;

    logic         clk;
    logic         rst;
    logic [255:0] in_data;
    logic [3:0]   in_bytecount;
    logic         in_rdy;
    logic         tx;
    logic         busy;
    logic         done;

    int nvec  = 0;
    int nfail = 0;
    logic [7:0] exp_bytes [16];

    resp_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_bytecount (in_bytecount),
        .in_rdy       (in_rdy),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected tx samples for one frame, one sample per clock
    function automatic logic [FRAME_LEN-1:0] frame_pattern(input logic [7:0] b);
        logic [FRAME_LEN-1:0] p;
        int pos;
        for (int i = 0; i < FRAME_LEN; i++) begin
            pos = i / CPB;
            if (pos == 0)      p[i] = 1'b0;
            else if (pos == 9) p[i] = 1'b1;
            else               p[i] = b[pos-1];
        end
        return p;
    endfunction

    // Produce a clean 0->1 on in_rdy; the edge following the raise is T
    task automatic raise_rdy();
        @(negedge clk); in_rdy = 1'b0;
        @(negedge clk); in_rdy = 1'b1;
    endtask

    // Follow a transfer from T. Check each frame against exp_bytes, then check
    // busy, done and tx. With perturb set, it toggles in_rdy and corrupts
    // in_data during frame 1.
    task automatic run_xfer(input string name, input int nframes, input bit perturb);
        logic [FRAME_LEN-1:0] obs, expf;
        int busy_low, done_hi;
        @(negedge clk);
        nvec++;
        if (busy !== 1'b1) begin
            nfail++; $display("FAIL %s busy_at_capture: got %b want 1", name, busy);
        end
        nvec++;
        if (tx !== 1'b1) begin
            nfail++; $display("FAIL %s tx_at_capture: got %b want 1", name, tx);
        end
        busy_low = 0;
        done_hi  = 0;
        for (int f = 0; f < nframes; f++) begin
            obs = '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                @(negedge clk);
                obs[i] = tx;
                if (busy !== 1'b1) busy_low++;
                if (done !== 1'b0) done_hi++;
                if (perturb && f == 1 && i == 10) begin
                    in_rdy  = 1'b0;
                    in_data = ~in_data;
                    in_bytecount = 4'hF;
                end
                if (perturb && f == 1 && i == 20) in_rdy = 1'b1;
            end
            expf = frame_pattern(exp_bytes[f]);
            nvec++;
            if (obs !== expf) begin
                nfail++;
                $display("FAIL %s frame%0d: got %h want %h", name, f, obs, expf);
            end
        end
        nvec++;
        if (busy_low != 0 || done_hi != 0) begin
            nfail++;
            $display("FAIL %s busy_done_during: busy_low=%0d done_hi=%0d want 0/0", name, busy_low, done_hi);
        end
        @(negedge clk);
        nvec++;
        if ({busy, done, tx} !== 3'b011) begin
            nfail++; $display("FAIL %s end_pulse: busy,done,tx got %b want 011", name, {busy, done, tx});
        end
        @(negedge clk);
        nvec++;
        if ({busy, done, tx} !== 3'b001) begin
            nfail++; $display("FAIL %s after_pulse: busy,done,tx got %b want 001", name, {busy, done, tx});
        end
    endtask

    // Expect the line to stay quiet for n cycles
    task automatic expect_quiet(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ({busy, done, tx} !== 3'b001) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nfail++; $display("FAIL %s quiet: %0d active cycles, want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_rdy = 1'b1; in_data = '0; in_bytecount = '0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({busy, done, tx} !== 3'b001) begin
            nfail++; $display("FAIL reset_values: busy,done,tx got %b want 001", {busy, done, tx});
        end
        // in_rdy held high across release must not start a transfer
        rst = 1'b0;
        expect_quiet("rdy_high_at_release", 20);
    endtask

    task automatic test_single();
        in_data = '0; in_data[7:0] = 8'hFE; in_bytecount = 4'd0;
        exp_bytes[0] = 8'hFE;
        raise_rdy();
        run_xfer("single", 1, 1'b0);
    endtask

    task automatic test_level_hold();
        // in_rdy still high from the previous transfer
        expect_quiet("level_hold", 50);
        in_data[7:0] = 8'h3C; exp_bytes[0] = 8'h3C;
        raise_rdy();
        run_xfer("retrigger", 1, 1'b0);
    endtask

    task automatic test_three();
        in_data = '0; in_data[23:0] = 24'h5AA501; in_bytecount = 4'd2;
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'hA5; exp_bytes[2] = 8'h5A;
        raise_rdy();
        run_xfer("three", 3, 1'b0);
    endtask

    task automatic test_perturb();
        in_data = '0; in_data[23:0] = 24'hC38E71; in_bytecount = 4'd2;
        exp_bytes[0] = 8'h71; exp_bytes[1] = 8'h8E; exp_bytes[2] = 8'hC3;
        raise_rdy();
        run_xfer("perturb", 3, 1'b1);
        // the re-raise happened while busy, so nothing may follow
        expect_quiet("perturb_no_queue", 50);
    endtask

    task automatic test_full();
        in_data = '1;
        for (int k = 0; k < 16; k++) begin
            in_data[8*k +: 8] = 8'(k);
            exp_bytes[k] = 8'(k);
        end
        in_bytecount = 4'd15;
        raise_rdy();
        run_xfer("full", 16, 1'b0);
    endtask

    task automatic test_reset_mid();
        in_data = '0; in_data[23:0] = 24'h5AA501; in_bytecount = 4'd2;
        raise_rdy();
        @(negedge clk);                 // after T
        repeat (60) @(negedge clk);     // inside byte 1 data bits
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if ({busy, done, tx} !== 3'b001) begin
            nfail++; $display("FAIL reset_mid: busy,done,tx got %b want 001", {busy, done, tx});
        end
        rst = 1'b0;
        expect_quiet("reset_mid_after", 60);
        in_data[7:0] = 8'hA5; in_bytecount = 4'd0; exp_bytes[0] = 8'hA5;
        raise_rdy();
        run_xfer("after_reset", 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_level_hold();
        test_three();
        test_perturb();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_resp_uart_tx
`default_nettype wire
